ar_tx_sched: RTL and testbench

Round-robin transmit scheduler that shares one ARINC-style serial transmitter (`AR_TXD`) among `NREQ` word sources. It arbitrates pending requests and loads the winner's 8-bit address and 23-bit data into the transmitter. It then pulses `st`, tracks the transmitter busy flag through the word, and enforces an inter-word gap before the next grant. It sits between the host-side word producers and the transmitter instance in the test/system top.

---
 rtl/ar_pkg.sv | 25 ++
 rtl/ar_rr_arb.sv | 31 +++
 rtl/ar_tx_sched.sv | 148 ++++++++++++++
 tb/tb_ar_tx_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ar_pkg.sv
// Shared definitions for the ARINC transmit scheduler.
//   AR_*_W       : word field widths (address, data, speed select, source index)
//   ar_sched_state_t : scheduler FSM states
//   ar_idx_w()   : index width for an N-entry requester set (at least 1 bit)
package ar_pkg;

  localparam int AR_ADR_W  = 8;
  localparam int AR_DAT_W  = 23;
  localparam int AR_NVEL_W = 2;
  localparam int AR_SRC_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_EN,
    ST_WAIT_DONE,
    ST_GAP
  } ar_sched_state_t;

  function automatic int ar_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ar_rr_arb.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per source
//   last : index of the most recently granted source
//   win  : first set request at or after (last+1) mod NREQ
//   vld  : any request set
module ar_rr_arb
  import ar_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = ar_idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   win,
  output logic            vld
);

  // Walk the ring from farthest to nearest so the nearest set bit after
  // 'last' is the one left standing.
  always_comb begin
    win = '0;
    vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[IW'((int'(last) + k) % NREQ)]) begin
        win = IW'((int'(last) + k) % NREQ);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ar_tx_sched.sv
// Round-robin scheduler sharing one ARINC serial transmitter among NREQ sources.
//   clk, rst_n        : clock, async active-low reset
//   req/adr_in/dat_in : per-source request level and word fields (source i at slice i)
//   nvel_cfg          : speed select, taken only while idle
//   ack               : one-hot pulse when a source's word is captured
//   busy              : high whenever not idle
//   err_tmo           : pulse when the transmitter never raised tx_en
//   cur_src           : index of the source being sent
//   tx_st/tx_adr/tx_dat/tx_nvel : transmitter load interface
//   tx_en, tx_ce      : transmitter word-in-progress flag and bit-time strobe
module ar_tx_sched
  import ar_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int GAP_TICKS = 4,
  parameter int TMO_CYC   = 64   // must be >= 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [AR_ADR_W*NREQ-1:0]   adr_in,
  input  logic [AR_DAT_W*NREQ-1:0]   dat_in,
  input  logic [AR_NVEL_W-1:0]       nvel_cfg,
  output logic [NREQ-1:0]            ack,
  output logic                       busy,
  output logic                       err_tmo,
  output logic [AR_SRC_W-1:0]        cur_src,
  output logic                       tx_st,
  output logic [AR_ADR_W-1:0]        tx_adr,
  output logic [AR_DAT_W-1:0]        tx_dat,
  output logic [AR_NVEL_W-1:0]       tx_nvel,
  input  logic                       tx_en,
  input  logic                       tx_ce
);

  localparam int IW = ar_idx_w(NREQ);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam int GW = $clog2(GAP_TICKS + 1);

  logic [NREQ-1:0][AR_ADR_W-1:0] adr_v;
  logic [NREQ-1:0][AR_DAT_W-1:0] dat_v;
  assign adr_v = adr_in;
  assign dat_v = dat_in;

  ar_sched_state_t state, state_nxt;
  logic [IW-1:0]   last;
  logic [TW-1:0]   tmo_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            en_q;
  logic            en_fall;
  logic            grant;
  logic            tmo_hit;
  logic [IW-1:0]   arb_win;
  logic            arb_vld;

  ar_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req  (req),
    .last (last),
    .win  (arb_win),
    .vld  (arb_vld)
  );

  assign en_fall = en_q & ~tx_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // tmo_cnt is 0 in the first WAIT_EN cycle (the one after tx_st), so
  // deciding at TMO_CYC-2 puts the registered err_tmo exactly TMO_CYC
  // cycles after tx_st.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_vld) begin
          state_nxt = ST_LOAD;
          grant     = 1'b1;
        end
      end
      ST_LOAD:  state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT_EN;
      ST_WAIT_EN: begin
        if (tx_en) begin
          state_nxt = ST_WAIT_DONE;
        end else if (tmo_cnt == TW'(TMO_CYC - 2)) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_WAIT_DONE: if (en_fall) state_nxt = ST_GAP;
      ST_GAP: if (tx_ce && gap_cnt == GW'(GAP_TICKS - 1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Winner is resolved in IDLE and registered on the IDLE->LOAD edge, so
  // ack and the captured word are both visible during LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      ack     <= '0;
      busy    <= 1'b0;
      err_tmo <= 1'b0;
      cur_src <= '0;
      tx_st   <= 1'b0;
      tx_adr  <= '0;
      tx_dat  <= '0;
      tx_nvel <= '0;
      last    <= IW'(NREQ - 1);
      tmo_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      en_q    <= tx_en;
      ack     <= '0;
      tx_st   <= 1'b0;
      err_tmo <= tmo_hit;
      busy    <= (state_nxt != ST_IDLE);

      if (state == ST_IDLE) tx_nvel <= nvel_cfg;

      if (grant) begin
        ack     <= NREQ'(1) << arb_win;
        cur_src <= AR_SRC_W'(arb_win);
        last    <= arb_win;
        tx_adr  <= adr_v[arb_win];
        tx_dat  <= dat_v[arb_win];
      end

      if (state == ST_LOAD) tx_st <= 1'b1;

      if (state == ST_START)
        tmo_cnt <= '0;
      else if (state == ST_WAIT_EN && !tx_en && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;

      // Fresh gap count on every entry, whether by word end or timeout.
      if (state_nxt == ST_GAP && state != ST_GAP)
        gap_cnt <= '0;
      else if (state == ST_GAP && tx_ce)
        gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ar_tx_sched.sv
// Directed bench for ar_tx_sched: grant table plus multi-cycle sequences
// for timeout, speed-select hold, async reset, back-to-back spacing and
// a request withdrawn before it could be granted.
module tb_ar_tx_sched;

  localparam int NREQ      = 4;
  localparam int GAP_TICKS = 4;
  localparam int TMO_CYC   = 64;

  logic        clk, rst_n;
  logic [3:0]  req;
  logic [31:0] adr_in;
  logic [91:0] dat_in;
  logic [1:0]  nvel_cfg;
  logic [3:0]  ack;
  logic        busy, err_tmo, tx_st, tx_en, tx_ce;
  logic [2:0]  cur_src;
  logic [7:0]  tx_adr;
  logic [22:0] tx_dat;
  logic [1:0]  tx_nvel;

  ar_tx_sched #(.NREQ(NREQ), .GAP_TICKS(GAP_TICKS), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .adr_in(adr_in), .dat_in(dat_in),
    .nvel_cfg(nvel_cfg), .ack(ack), .busy(busy), .err_tmo(err_tmo),
    .cur_src(cur_src), .tx_st(tx_st), .tx_adr(tx_adr), .tx_dat(tx_dat),
    .tx_nvel(tx_nvel), .tx_en(tx_en), .tx_ce(tx_ce)
  );

  int nchk = 0;
  int nerr = 0;
  logic tie_low = 1'b0;
  int   ce_since = 0;
  logic en_prev = 1'b0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [2:0]  src;
    logic [7:0]  adr;
    logic [22:0] dat;
  } vec_t;
  vec_t vt[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit-time strobe: one pulse every 4 clocks.
  initial begin
    tx_ce = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 tx_ce = 1'b1;
      @(posedge clk);
      #1 tx_ce = 1'b0;
    end
  end

  // Transmitter stand-in: tx_en rises 2 clocks after tx_st, lasts 20 clocks.
  initial begin
    tx_en = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_st && !tie_low) begin
        repeat (2) @(posedge clk);
        #1 tx_en = 1'b1;
        repeat (20) @(posedge clk);
        #1 tx_en = 1'b0;
      end
    end
  end

  // tx_ce pulses seen since the last tx_en fall.
  initial begin
    forever begin
      @(posedge clk);
      if (en_prev && !tx_en) ce_since = 0;
      else if (tx_ce)        ce_since++;
      en_prev = tx_en;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < budget);
    if (ack == '0) begin
      nchk++; nerr++;
      $display("FAIL ack_wait: got none want ack within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    if (busy) begin
      nchk++; nerr++;
      $display("FAIL idle_wait: got busy want idle within %0d cycles", budget);
    end
  endtask

  task automatic wait_en(input logic lvl, input int budget);
    int n = 0;
    while (tx_en !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx_en !== lvl) begin
      nchk++; nerr++;
      $display("FAIL en_wait: got tx_en=%0b want %0b", tx_en, lvl);
    end
  endtask

  initial begin
    int n;
    int bad;
    logic [3:0] exp_ack;

    vt[0] = '{4'b0001, 4'b0001, 3'd0, 8'hA5, 23'h12345};
    vt[1] = '{4'b0011, 4'b0010, 3'd1, 8'h3C, 23'h7ABCD};
    vt[2] = '{4'b0011, 4'b0001, 3'd0, 8'hA5, 23'h12345};
    vt[3] = '{4'b1100, 4'b0100, 3'd2, 8'h96, 23'h00001};
    vt[4] = '{4'b1001, 4'b1000, 3'd3, 8'h0F, 23'h555AA};
    vt[5] = '{4'b0110, 4'b0010, 3'd1, 8'h3C, 23'h7ABCD};
    vt[6] = '{4'b1111, 4'b0100, 3'd2, 8'h96, 23'h00001};
    vt[7] = '{4'b0001, 4'b0001, 3'd0, 8'hA5, 23'h12345};

    adr_in   = {8'h0F, 8'h96, 8'h3C, 8'hA5};
    dat_in   = {23'h555AA, 23'h00001, 23'h7ABCD, 23'h12345};
    nvel_cfg = 2'b11;
    req      = 4'b1111;
    rst_n    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_tmo, 0);
    chk("rst_src", cur_src, 0);
    chk("rst_st", tx_st, 0);
    chk("rst_adr", tx_adr, 0);
    chk("rst_dat", tx_dat, 0);
    chk("rst_nvel", tx_nvel, 0);
    req = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_nvel_load", tx_nvel, 2'b11);
    nvel_cfg = 2'b00;

    // Grant table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req = vt[i].req;
      wait_ack(20, n);
      chk($sformatf("v%0d_latency", i), n, 1);
      chk($sformatf("v%0d_ack", i), ack, vt[i].ack);
      chk($sformatf("v%0d_src", i), cur_src, vt[i].src);
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_st_early", i), tx_st, 0);
      req = '0;
      @(negedge clk);
      chk($sformatf("v%0d_st", i), tx_st, 1);
      chk($sformatf("v%0d_adr", i), tx_adr, vt[i].adr);
      chk($sformatf("v%0d_dat", i), tx_dat, vt[i].dat);
      chk($sformatf("v%0d_ack_pulse", i), ack, 0);
      @(negedge clk);
      chk($sformatf("v%0d_st_pulse", i), tx_st, 0);
      wait_idle(400);
    end

    // Transmitter never starts: timeout, drop, next grant proceeds
    tie_low = 1'b1;
    @(negedge clk);
    req = 4'b0110;
    wait_ack(20, n);
    chk("tmo_ack1", ack, 4'b0010);
    req = 4'b0100;
    @(negedge clk);
    chk("tmo_st", tx_st, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_tmo && n < 200);
    chk("tmo_delay", n, TMO_CYC);
    @(negedge clk);
    chk("tmo_pulse", err_tmo, 0);
    chk("tmo_gap_busy", busy, 1);
    tie_low = 1'b0;
    wait_ack(100, n);
    chk("tmo_next_ack", ack, 4'b0100);
    req = '0;
    wait_idle(400);

    // Speed select held through the word
    nvel_cfg = 2'b01;
    repeat (2) @(negedge clk);
    req = 4'b0001;
    wait_ack(20, n);
    chk("nvel_ack", ack, 4'b0001);
    req = '0;
    nvel_cfg = 2'b10;
    @(negedge clk);
    chk("nvel_at_st", tx_nvel, 2'b01);
    wait_en(1'b1, 20);
    chk("nvel_mid", tx_nvel, 2'b01);
    wait_idle(400);
    chk("nvel_first_idle", tx_nvel, 2'b01);
    @(negedge clk);
    chk("nvel_after_idle", tx_nvel, 2'b10);

    // Async reset in WAIT_DONE
    req = 4'b0100;
    wait_ack(20, n);
    chk("rmid_ack", ack, 4'b0100);
    req = '0;
    wait_en(1'b1, 20);
    @(negedge clk);
    chk("rmid_busy_pre", busy, 1);
    chk("rmid_src_pre", cur_src, 2);
    rst_n = 1'b0;
    #1;
    chk("rmid_busy", busy, 0);
    chk("rmid_st", tx_st, 0);
    chk("rmid_ack0", ack, 0);
    chk("rmid_src", cur_src, 0);
    chk("rmid_adr", tx_adr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_en(1'b0, 40);
    repeat (2) @(negedge clk);

    // All four held: strict rotation from source 0, gap-limited spacing
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_ack = 4'b0001 << (g % 4);
      wait_ack(300, n);
      chk($sformatf("rr%0d_ack", g), ack, exp_ack);
      @(negedge clk);
      chk($sformatf("rr%0d_st", g), tx_st, 1);
      chk($sformatf("rr%0d_adr", g), tx_adr, adr_in[8*(g%4) +: 8]);
      if (g > 0) chk($sformatf("rr%0d_gap_ticks", g), ce_since, GAP_TICKS);
    end
    req = '0;
    wait_idle(400);

    // Request raised and withdrawn during GAP is never served
    @(negedge clk);
    req = 4'b0100;
    wait_ack(20, n);
    chk("drop_ack_first", ack, 4'b0100);
    req = '0;
    wait_en(1'b1, 20);
    wait_en(1'b0, 40);
    @(posedge clk); #1 req = 4'b0010;
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk);
    chk("drop_in_gap", busy, 1);
    wait_idle(400);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ack != 0 || tx_st || busy) bad++;
    end
    chk("drop_quiet", bad, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
